// File: rtl/alu_load_sequencer_pkg.sv
// Shared definitions for the ALU test datapath load sequencer.
// Contents:
//   seq_state_t         - load sequencer state encoding (LOAD_A..SHOW)
//   DEFAULT_N_SW        - default switch bus width
//   DEFAULT_N_OP        - default opcode width
//   DEFAULT_N_OPERANDS  - default operand width
package alu_test_pkg;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      SHOW    = 2'd3
   } seq_state_t;

   localparam int DEFAULT_N_SW       = 16;
   localparam int DEFAULT_N_OP       = 6;
   localparam int DEFAULT_N_OPERANDS = 4;

endpackage

// File: rtl/alu_load_sequencer_if.sv
// Board-side bundle of the load sequencer: switches and buttons in,
// ALU operand/opcode bus and status out.
// Modports:
//   master - the board / stimulus side (drives sw and buttons)
//   slave  - the sequencer side (drives ALU bus, state and result_valid)
interface alu_load_sequencer_if
   import alu_test_pkg::*;
#(
   parameter int N_SW       = DEFAULT_N_SW,
   parameter int N_OP       = DEFAULT_N_OP,
   parameter int N_OPERANDS = DEFAULT_N_OPERANDS
);
   logic [N_SW-1:0]       sw;
   logic                  button_next;
   logic                  button_clear;
   logic [N_OPERANDS-1:0] alu_a;
   logic [N_OPERANDS-1:0] alu_b;
   logic [N_OP-1:0]       alu_op;
   logic [1:0]            state;
   logic                  result_valid;

   modport master (
      output sw, button_next, button_clear,
      input  alu_a, alu_b, alu_op, state, result_valid
   );

   modport slave (
      input  sw, button_next, button_clear,
      output alu_a, alu_b, alu_op, state, result_valid
   );
endinterface

// File: rtl/alu_load_sequencer_button_debouncer.sv
// button_debouncer: turns a raw asynchronous button into a single-cycle
// press pulse.  Chain: 2-flop synchronizer -> stable-sample register ->
// debounced level -> rising-edge detect.
// Build option: ALU_SEQ_DEBOUNCE_EN
//   defined   - debounced level flips only after DB_CYCLES consecutive
//               cycles of disagreement with the sampled level
//   undefined - debounced level is the sampled synchronizer output, no counter
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   button - raw button level
//   press  - one-cycle pulse on each debounced rising edge
module button_debouncer #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic press
);

   generate
      if (DB_CYCLES < 2) begin : g_bad_db
         $error("button_debouncer: DB_CYCLES must be >= 2");
      end
   endgenerate

   logic sync1_reg;
   logic sync2_reg;
   logic sample_reg;
   logic db_level;
   logic db_prev_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b0;
         sync2_reg   <= 1'b0;
         sample_reg  <= 1'b0;
         db_prev_reg <= 1'b0;
      end else begin
         sync1_reg   <= button;
         sync2_reg   <= sync1_reg;
         sample_reg  <= sync2_reg;
         db_prev_reg <= db_level;
      end
   end

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DB_CYCLES);

   logic [CNT_W-1:0] cnt_reg;
   logic             db_reg;

   // The counter never wraps: reaching the terminal count flips the level,
   // after which the levels agree again and the counter is cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         db_reg  <= 1'b0;
      end else if (sample_reg == db_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
         db_reg  <= sample_reg;
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign db_level = db_reg;
`else
   assign db_level = sample_reg;
`endif

   // Rising edge only: holding gives one pulse, release gives none.
   assign press = db_level & ~db_prev_reg;

endmodule

// File: rtl/alu_load_sequencer.sv
// alu_load_sequencer: single "next" button steps through loading operand A,
// operand B and the opcode from the switches, then a result-display state.
// A "clear" button zeroes all stored values and returns to LOAD_A.
// Build option: ALU_SEQ_DEBOUNCE_EN (enables the button debounce counters).
// Ports:
//   i_clock, i_reset_n       - clock, asynchronous active-low reset
//   i_sw                     - switches: A=[NA-1:0], B=[2NA-1:NA], Op above B
//   i_button_next            - raw button: latch current field and advance
//   i_button_clear           - raw button: clear everything
//   o_alu_A, o_alu_B, o_alu_Op - stored operands and opcode
//   o_state                  - state code (LOAD_A=0 .. SHOW=3)
//   o_result_valid           - high while in SHOW
module alu_load_sequencer
   import alu_test_pkg::*;
#(
   parameter int N_SW       = DEFAULT_N_SW,
   parameter int N_OP       = DEFAULT_N_OP,
   parameter int N_OPERANDS = DEFAULT_N_OPERANDS,
   parameter int DB_CYCLES  = 1000000
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic [N_SW-1:0]       i_sw,
   input  logic                  i_button_next,
   input  logic                  i_button_clear,
   output logic [N_OPERANDS-1:0] o_alu_A,
   output logic [N_OPERANDS-1:0] o_alu_B,
   output logic [N_OP-1:0]       o_alu_Op,
   output logic [1:0]            o_state,
   output logic                  o_result_valid
);

   localparam int FIELD_W = 2 * N_OPERANDS + N_OP;

   generate
      if (N_SW < FIELD_W) begin : g_bad_width
         $error("alu_load_sequencer: N_SW must be >= 2*N_OPERANDS+N_OP");
      end else if (N_SW > FIELD_W) begin : g_spare_sw
         // Switches above the opcode field are not used.
         logic unused_sw;
         assign unused_sw = ^i_sw[N_SW-1:FIELD_W];
      end
   endgenerate

   logic press_next;
   logic press_clear;

   button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_next (
      .clk    (i_clock),
      .rst_n  (i_reset_n),
      .button (i_button_next),
      .press  (press_next)
   );

   button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk    (i_clock),
      .rst_n  (i_reset_n),
      .button (i_button_clear),
      .press  (press_clear)
   );

   // Switches are treated as static, so they are sampled directly.
   logic [N_OPERANDS-1:0] sw_a;
   logic [N_OPERANDS-1:0] sw_b;
   logic [N_OP-1:0]       sw_op;

   assign sw_a  = i_sw[N_OPERANDS-1:0];
   assign sw_b  = i_sw[2*N_OPERANDS-1:N_OPERANDS];
   assign sw_op = i_sw[FIELD_W-1:2*N_OPERANDS];

   seq_state_t            state_reg;
   logic [N_OPERANDS-1:0] a_reg;
   logic [N_OPERANDS-1:0] b_reg;
   logic [N_OP-1:0]       op_reg;
   logic                  valid_reg;

   // Clear has priority over next when both pulse in the same cycle.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= LOAD_A;
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= '0;
         valid_reg <= 1'b0;
      end else if (press_clear) begin
         state_reg <= LOAD_A;
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= '0;
         valid_reg <= 1'b0;
      end else if (press_next) begin
         case (state_reg)
            LOAD_A: begin
               a_reg     <= sw_a;
               state_reg <= LOAD_B;
            end
            LOAD_B: begin
               b_reg     <= sw_b;
               state_reg <= LOAD_OP;
            end
            LOAD_OP: begin
               op_reg    <= sw_op;
               state_reg <= SHOW;
               valid_reg <= 1'b1;
            end
            SHOW: begin
               state_reg <= LOAD_A;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign o_alu_A        = a_reg;
   assign o_alu_B        = b_reg;
   assign o_alu_Op       = op_reg;
   assign o_state        = state_reg;
   assign o_result_valid = valid_reg;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Directed testbench for alu_load_sequencer with DB_CYCLES=4.
// Works with ALU_SEQ_DEBOUNCE_EN defined (update at edge 7) or undefined
// (update at edge 3).
module tb_alu_load_sequencer;

   localparam int N_SW       = 16;
   localparam int N_OP       = 6;
   localparam int N_OPERANDS = 4;
   localparam int DB         = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int LAT = DB + 3;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_load_sequencer_if #(.N_SW(N_SW), .N_OP(N_OP), .N_OPERANDS(N_OPERANDS)) bus ();

   alu_load_sequencer #(
      .N_SW(N_SW), .N_OP(N_OP), .N_OPERANDS(N_OPERANDS), .DB_CYCLES(DB)
   ) dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_sw           (bus.sw),
      .i_button_next  (bus.button_next),
      .i_button_clear (bus.button_clear),
      .o_alu_A        (bus.alu_a),
      .o_alu_B        (bus.alu_b),
      .o_alu_Op       (bus.alu_op),
      .o_state        (bus.state),
      .o_result_valid (bus.result_valid)
   );

   // Observed outputs packed as {A, B, Op, state, valid}.
   wire [16:0] obs = {bus.alu_a, bus.alu_b, bus.alu_op, bus.state, bus.result_valid};

   function automatic logic [16:0] pack(input logic [3:0] a, input logic [3:0] b,
                                        input logic [5:0] op, input logic [1:0] st,
                                        input logic v);
      return {a, b, op, st, v};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise buttons now; the next edge is edge 0. Returns just after edge LAT-1.
   task automatic start_press(input logic nxt, input logic clr);
      bus.button_next  = nxt;
      bus.button_clear = clr;
      tick(LAT);
   endtask

   task automatic release_all();
      bus.button_next  = 1'b0;
      bus.button_clear = 1'b0;
      tick(LAT + 4);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus.sw = '0;
      bus.button_next = 1'b0;
      bus.button_clear = 1'b0;
      #1 rst_n = 1'b0;
      tick(2);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      rst_n = 1'b1;
      tick(3);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_release: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      $display("reset: outputs %h", obs);
   endtask

   task automatic test_full_sequence();
      logic [16:0] exp_seq [0:3];
      exp_seq[0] = pack(4'h3 & 4'h0, 0, 0, 0, 0);
      exp_seq[1] = pack(4'h3, 0, 0, 1, 0);
      exp_seq[2] = pack(4'h3, 4'hA, 0, 2, 0);
      exp_seq[3] = pack(4'h3, 4'hA, 6'h20, 3, 1);
      bus.sw = 16'h20A3;
      for (int i = 1; i < 4; i++) begin
         start_press(1'b1, 1'b0);
         checks++;
         if (obs !== exp_seq[i-1]) begin
            errors++;
            $display("FAIL seq%0d_early: got %h expected %h", i, obs, exp_seq[i-1]);
         end
         tick(1);
         checks++;
         if (obs !== exp_seq[i]) begin
            errors++;
            $display("FAIL seq%0d_update: got %h expected %h", i, obs, exp_seq[i]);
         end
         tick(50);
         checks++;
         if (obs !== exp_seq[i]) begin
            errors++;
            $display("FAIL seq%0d_hold: got %h expected %h", i, obs, exp_seq[i]);
         end
         release_all();
         checks++;
         if (obs !== exp_seq[i]) begin
            errors++;
            $display("FAIL seq%0d_release: got %h expected %h", i, obs, exp_seq[i]);
         end
         $display("sequence press %0d: outputs %h", i, obs);
      end
   endtask

   task automatic test_glitch();
`ifdef ALU_SEQ_DEBOUNCE_EN
      bus.button_next = 1'b1;
      tick(3);
      bus.button_next = 1'b0;
      tick(20);
      checks++;
      if (obs !== pack(4'h3, 4'hA, 6'h20, 3, 1)) begin
         errors++;
         $display("FAIL glitch_3cyc: got %h expected %h", obs, pack(4'h3, 4'hA, 6'h20, 3, 1));
      end
      $display("glitch 3 cycles: outputs %h", obs);
`endif
   endtask

   task automatic test_show_wrap();
      bus.sw = 16'h1165;
      start_press(1'b1, 1'b0);
      checks++;
      if (obs !== pack(4'h3, 4'hA, 6'h20, 3, 1)) begin
         errors++;
         $display("FAIL wrap_early: got %h expected %h", obs, pack(4'h3, 4'hA, 6'h20, 3, 1));
      end
      tick(1);
      checks++;
      if (obs !== pack(4'h3, 4'hA, 6'h20, 0, 0)) begin
         errors++;
         $display("FAIL wrap_update: got %h expected %h", obs, pack(4'h3, 4'hA, 6'h20, 0, 0));
      end
      release_all();
      start_press(1'b1, 1'b0);
      tick(1);
      checks++;
      if (obs !== pack(4'h5, 4'hA, 6'h20, 1, 0)) begin
         errors++;
         $display("FAIL wrap_new_a: got %h expected %h", obs, pack(4'h5, 4'hA, 6'h20, 1, 0));
      end
      release_all();
      $display("show wrap: outputs %h", obs);
   endtask

   task automatic test_clear_and_next();
      start_press(1'b1, 1'b0);
      tick(1);
      checks++;
      if (obs !== pack(4'h5, 4'h6, 6'h20, 2, 0)) begin
         errors++;
         $display("FAIL clr_setup: got %h expected %h", obs, pack(4'h5, 4'h6, 6'h20, 2, 0));
      end
      release_all();
      start_press(1'b1, 1'b1);
      checks++;
      if (obs !== pack(4'h5, 4'h6, 6'h20, 2, 0)) begin
         errors++;
         $display("FAIL clr_early: got %h expected %h", obs, pack(4'h5, 4'h6, 6'h20, 2, 0));
      end
      tick(1);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL clr_update: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      tick(50);
      release_all();
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL clr_hold: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      $display("clear+next: outputs %h", obs);
   endtask

   // One-cycle raw pulse seen by exactly one edge.
   task automatic test_short_pulse();
      bus.button_next = 1'b1;
      tick(1);
      bus.button_next = 1'b0;
`ifdef ALU_SEQ_DEBOUNCE_EN
      tick(20);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL pulse_ignored: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      start_press(1'b1, 1'b0);
      tick(1);
      release_all();
`else
      tick(2);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL pulse_early: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      tick(1);
      checks++;
      if (obs !== pack(4'h5, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL pulse_advance: got %h expected %h", obs, pack(4'h5, 0, 0, 1, 0));
      end
      tick(10);
`endif
      checks++;
      if (obs !== pack(4'h5, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL pulse_final: got %h expected %h", obs, pack(4'h5, 0, 0, 1, 0));
      end
      $display("short pulse: outputs %h", obs);
   endtask

   task automatic test_reset_mid();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      bus.button_next = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(LAT);
      checks++;
      if (obs !== pack(0, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_held_early: got %h expected %h", obs, pack(0, 0, 0, 0, 0));
      end
      tick(1);
      checks++;
      if (obs !== pack(4'h5, 0, 0, 1, 0)) begin
         errors++;
         $display("FAIL reset_held_press: got %h expected %h", obs, pack(4'h5, 0, 0, 1, 0));
      end
      release_all();
      $display("reset mid-sequence: outputs %h", obs);
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_glitch();
      test_show_wrap();
      test_clear_and_next();
      test_short_pulse();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_load_sequencer.md
# alu_load_sequencer

Single-button load sequencer for the ALU test datapath. It replaces three independent load buttons with one debounced "next" button. A four-state FSM steps through loading operand A, operand B and the opcode from the board switches, then a result-display state. A second button clears all stored values. The outputs drive the ALU operand and opcode inputs directly, and the state code drives board LEDs.

## Interface
Parameters:
- N_SW, 16, switch bus width; must be ≥ 2*N_OPERANDS+N_OP, otherwise elaboration error
- N_OP, 6, opcode width
- N_OPERANDS, 4, operand width
- DB_CYCLES, 1000000, debounce stability window in clock cycles, ≥ 2

Ports:
- i_clock, input, 1, single system clock, rising edge
- i_reset_n, input, 1, asynchronous active-low reset
- i_sw, input, N_SW, raw switch levels, quasi-static
- i_button_next, input, 1, raw asynchronous button: latch current field and advance
- i_button_clear, input, 1, raw asynchronous button: clear all registers
- o_alu_A, output, N_OPERANDS, stored operand A
- o_alu_B, output, N_OPERANDS, stored operand B
- o_alu_Op, output, N_OP, stored opcode
- o_state, output, 2, current FSM state code
- o_result_valid, output, 1, high while in SHOW

## Operation
- Switch fields:
  - A = i_sw[N_OPERANDS-1:0]
  - B = i_sw[2*N_OPERANDS-1:N_OPERANDS]
  - Op = i_sw[2*N_OPERANDS+N_OP-1:2*N_OPERANDS]
- Each button passes through a 2-flop synchronizer, then the debouncer, then a rising-edge detect, producing a 1-cycle pulse (press_next, press_clear).
- FSM states and codes: LOAD_A=0, LOAD_B=1, LOAD_OP=2, SHOW=3.
- On press_next:
  - LOAD_A: store A field, go to LOAD_B.
  - LOAD_B: store B field, go to LOAD_OP.
  - LOAD_OP: store Op field, go to SHOW.
  - SHOW: go to LOAD_A; stored registers are retained.
- On press_clear, from any state: A, B and Op are set to 0 and the state goes to LOAD_A.
- press_clear and press_next in the same cycle: clear wins and next is discarded.
- Without a press, the state and registers hold.
- Holding a button produces exactly one pulse per press. Release generates no pulse.
- o_result_valid = (state == SHOW).

## Timing
- Reset (asynchronous assert, synchronous release by the clock):
  - o_alu_A, o_alu_B, o_alu_Op = 0; o_state = 0; o_result_valid = 0.
  - Synchronizers, debounced levels and counters = 0.
- Reset asserted mid-sequence immediately returns the block to LOAD_A with zeroed registers. A button held through reset release generates a press only after it is debounced high from the low reset state.
- Debouncer:
  - The counter increments each cycle the synchronized level differs from the debounced level, and resets to 0 whenever they match.
  - When the counter reaches DB_CYCLES-1 while the levels still differ, the debounced level flips on that edge.
  - Pulses shorter than DB_CYCLES cycles are ignored.
- Latency, with edge 0 being the first edge that samples the raw button high (held stable):
  - Debounced level high at edge DB_CYCLES+2.
  - Press pulse is combinational in the following cycle.
  - Outputs and o_state update at edge DB_CYCLES+3.
- Counter width is $clog2(DB_CYCLES); there is no wrap, because the counter saturates by flipping.
- i_sw is sampled in the press cycle only. No switch synchronizer is used; the switches are treated as static.

## Configuration
- ALU_SEQ_DEBOUNCE_EN defined: the debouncer is instantiated as described above.
- ALU_SEQ_DEBOUNCE_EN undefined:
  - The debouncer is bypassed; the debounced level equals the synchronizer output.
  - Latency becomes 3 edges.
  - DB_CYCLES is ignored and no counter logic is built.

## Structure
- Shared package alu_test_pkg:
  - State typedef and the encodings LOAD_A..SHOW.
  - Default widths N_SW, N_OP, N_OPERANDS.
- Sub-module button_debouncer (synchronizer, counter, edge detect), parameter DB_CYCLES.
  - Instantiated twice, for next and clear.
  - The ALU_SEQ_DEBOUNCE_EN macro is evaluated inside it.

## Test plan
Bench uses DB_CYCLES=4 with macro defined unless noted.
- Reset check: assert i_reset_n=0 mid-sequence with A=5 stored -> all outputs 0 and o_state=0 immediately, without waiting for a clock edge.
- Full sequence: set sw fields A=0x3, B=0xA, Op=0x20 and press next three times -> after each update o_alu_A=3, then o_alu_B=0xA, then o_alu_Op=0x20; o_state 1, 2, 3; o_result_valid=1 after the third press.
- Glitch rejection: 3-cycle high glitch on next -> no state change. Held press -> update exactly at edge 7 (DB_CYCLES+3), and only once despite a 50-cycle hold.
- SHOW wrap: in SHOW, change switches and press next -> o_state=0, registers unchanged. The next press loads the new A.
- Clear: clear and next debounced on the same cycle in LOAD_OP -> A=B=Op=0, o_state=0, opcode not loaded.
- Macro undefined: single held press -> update at edge 3. A 1-cycle-wide raw pulse that is caught by the synchronizer -> advances one state.
